// File: rtl/rng_collector_if.sv
// Handshake and data bundle between the RingRNG collector, the RingRNG core and the
// key-generation consumer. The collector is the master.
interface rng_collector_if #(
   parameter int WIDTH = 256
);
   logic             start;
   logic             rng_en;
   logic [31:0]      rng_in;
   logic [WIDTH-1:0] rand_out;
   logic             rand_valid;
   logic             rand_ready;
   logic             busy;
   logic             health_fail;

   modport master (
      input  start, rng_in, rand_ready,
      output rng_en, rand_out, rand_valid, busy, health_fail
   );

   modport slave (
      output start, rng_in, rand_ready,
      input  rng_en, rand_out, rand_valid, busy, health_fail
   );
endinterface

// File: rtl/rng_collector.sv
// Collects decimated, repetition-checked RingRNG words into one WIDTH-bit value,
// optionally forcing the top and bottom bits so the result is an odd full-length candidate.
module rng_collector #(
   parameter int WIDTH      = 256,
   parameter int WARMUP     = 64,
   parameter int SAMPLE_DIV = 4,
   parameter int FORCE_ODD  = 1,
   parameter int REP_LIMIT  = 3
) (
   input  logic            clk,
   input  logic            rst,
   rng_collector_if.master bus
);
   localparam int WORDS  = WIDTH / 32;
   localparam int CYC_W  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int WIDX_W = $clog2(WORDS);
   localparam int REP_W  = $clog2(REP_LIMIT + 1);

   localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(WARMUP - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORDS - 1);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_LIMIT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WARMUP,
      S_COLLECT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [WIDX_W-1:0] word_idx_q, word_idx_d;
   logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
   logic              prev_valid_q, prev_valid_d;
   logic              health_fail_q, health_fail_d;
   logic              rng_en_q, rand_valid_q, busy_q;
   logic [WIDTH-1:0]  rand_out_q, rand_out_d;
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic [31:0]       prev_word_q, prev_word_d;

   function automatic logic [WIDTH-1:0] force_odd(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = v;
      if (FORCE_ODD != 0) begin
         r[WIDTH-1] = 1'b1;
         r[0]       = 1'b1;
      end
      return r;
   endfunction

   always_comb begin
      state_d       = state_q;
      cyc_cnt_d     = cyc_cnt_q;
      div_cnt_d     = div_cnt_q;
      word_idx_d    = word_idx_q;
      rep_cnt_d     = rep_cnt_q;
      prev_valid_d  = prev_valid_q;
      health_fail_d = health_fail_q;
      rand_out_d    = rand_out_q;
      acc_d         = acc_q;
      prev_word_d   = prev_word_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d       = S_WARMUP;
               cyc_cnt_d     = '0;
               div_cnt_d     = '0;
               word_idx_d    = '0;
               rep_cnt_d     = '0;
               prev_valid_d  = 1'b0;
               health_fail_d = 1'b0;
            end
         end

         S_WARMUP: begin
            if (cyc_cnt_q == CYC_LAST) begin
               state_d   = S_COLLECT;
               cyc_cnt_d = '0;
               div_cnt_d = '0;
            end else begin
               cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
            end
         end

         S_COLLECT: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               // A repeated raw word is dropped without updating prev_word, so a run keeps counting.
               if (prev_valid_q && (bus.rng_in == prev_word_q)) begin
                  rep_cnt_d = rep_cnt_q + REP_W'(1);
                  if (rep_cnt_q == REP_LAST) begin
                     health_fail_d = 1'b1;
                     state_d       = S_IDLE;
                  end
               end else begin
                  acc_d        = {acc_q[WIDTH-33:0], bus.rng_in};
                  prev_word_d  = bus.rng_in;
                  prev_valid_d = 1'b1;
                  rep_cnt_d    = '0;
                  word_idx_d   = word_idx_q + WIDX_W'(1);
                  if (word_idx_q == WIDX_LAST) begin
                     state_d    = S_DONE;
                     word_idx_d = '0;
                     rand_out_d = force_odd(acc_d);
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end

         S_DONE: begin
            if (bus.rand_ready) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Control state and registered outputs; outputs follow the next state so they are glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cyc_cnt_q     <= '0;
         div_cnt_q     <= '0;
         word_idx_q    <= '0;
         rep_cnt_q     <= '0;
         prev_valid_q  <= 1'b0;
         health_fail_q <= 1'b0;
         rng_en_q      <= 1'b0;
         rand_valid_q  <= 1'b0;
         busy_q        <= 1'b0;
         rand_out_q    <= '0;
      end else begin
         state_q       <= state_d;
         cyc_cnt_q     <= cyc_cnt_d;
         div_cnt_q     <= div_cnt_d;
         word_idx_q    <= word_idx_d;
         rep_cnt_q     <= rep_cnt_d;
         prev_valid_q  <= prev_valid_d;
         health_fail_q <= health_fail_d;
         rng_en_q      <= (state_d == S_WARMUP) || (state_d == S_COLLECT);
         rand_valid_q  <= (state_d == S_DONE);
         busy_q        <= (state_d != S_IDLE);
         rand_out_q    <= rand_out_d;
      end
   end

   always_ff @(posedge clk) begin
      acc_q       <= acc_d;
      prev_word_q <= prev_word_d;
   end

   assign bus.rng_en      = rng_en_q;
   assign bus.rand_out    = rand_out_q;
   assign bus.rand_valid  = rand_valid_q;
   assign bus.busy        = busy_q;
   assign bus.health_fail = health_fail_q;
endmodule

// File: tb/tb_rng_collector.sv
// Bench for rng_collector: a FORCE_ODD=1 and a FORCE_ODD=0 instance share the same stimulus;
// expected results go to per-instance queues and a monitor checks them when rand_valid rises.
module tb_rng_collector;
   localparam int WIDTH = 64;
   localparam int WARM  = 4;
   localparam int SDIV  = 2;

   typedef struct {
      logic [63:0] val;
      int          edge_no;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] rng_in = 32'h0;
   logic        rand_ready = 1'b0;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   exp_t        qa[$];
   exp_t        qb[$];
   logic [31:0] wv[4];
   logic        pv[2];
   logic        hs[2];
   logic [63:0] held[2];

   rng_collector_if #(.WIDTH(WIDTH)) bus_a ();
   rng_collector_if #(.WIDTH(WIDTH)) bus_b ();

   assign bus_a.start      = start;
   assign bus_a.rng_in     = rng_in;
   assign bus_a.rand_ready = rand_ready;
   assign bus_b.start      = start;
   assign bus_b.rng_in     = rng_in;
   assign bus_b.rand_ready = rand_ready;

   rng_collector #(.WIDTH(WIDTH), .WARMUP(WARM), .SAMPLE_DIV(SDIV), .FORCE_ODD(1), .REP_LIMIT(3))
      dut_odd (.clk(clk), .rst(rst), .bus(bus_a));
   rng_collector #(.WIDTH(WIDTH), .WARMUP(WARM), .SAMPLE_DIV(SDIV), .FORCE_ODD(0), .REP_LIMIT(3))
      dut_raw (.clk(clk), .rst(rst), .bus(bus_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mon(input int id, input logic v, input logic [63:0] ro, input logic en,
                      input logic bz, input logic rdy);
      exp_t e;
      int   sz;
      if (hs[id]) chk1($sformatf("valid_drop%0d", id), v, 1'b0);
      if (v && !pv[id]) begin
         sz = (id == 0) ? qa.size() : qb.size();
         if (sz == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid%0d: got rand_out 0x%0h with no result expected", id, ro);
            held[id] = ro;
         end else begin
            e = (id == 0) ? qa.pop_front() : qb.pop_front();
            chk($sformatf("rand_out%0d", id), ro, e.val);
            chk($sformatf("latency%0d", id), 64'(cyc + 1), 64'(e.edge_no));
            held[id] = e.val;
         end
      end else if (v) begin
         chk($sformatf("hold%0d", id), ro, held[id]);
      end
      if (v) begin
         chk1($sformatf("rng_en_done%0d", id), en, 1'b0);
         chk1($sformatf("busy_done%0d", id), bz, 1'b1);
      end
      hs[id] = v && rdy;
      pv[id] = v;
   endtask

   initial begin
      pv[0] = 1'b0; pv[1] = 1'b0;
      hs[0] = 1'b0; hs[1] = 1'b0;
      held[0] = '0; held[1] = '0;
   end

   always @(posedge clk) begin
      #1;
      mon(0, bus_a.rand_valid, bus_a.rand_out, bus_a.rng_en, bus_a.busy, rand_ready);
      mon(1, bus_b.rand_valid, bus_b.rand_out, bus_b.rng_en, bus_b.busy, rand_ready);
   end

   task automatic chk_idle(input string tag, input logic hf);
      chk1({tag, "_rng_en"}, bus_a.rng_en, 1'b0);
      chk1({tag, "_valid"}, bus_a.rand_valid, 1'b0);
      chk1({tag, "_busy"}, bus_a.busy, 1'b0);
      chk1({tag, "_hfail"}, bus_a.health_fail, hf);
      chk1({tag, "_hfail_raw"}, bus_b.health_fail, hf);
   endtask

   // Issues one request with words wv[0..n-1] presented one per sample slot.
   task automatic run_req(input int n, input logic [63:0] ea, input logic [63:0] eb,
                          input int lat, input bit ok, input int hold);
      int   k;
      exp_t e;
      chk1("queue_empty_before_start", ((qa.size() == 0) && (qb.size() == 0)), 1'b1);
      rand_ready = (hold == 0);
      @(negedge clk);
      start = 1'b1;
      k = cyc + 1;
      if (ok) begin
         e.val = ea; e.edge_no = k + lat; qa.push_back(e);
         e.val = eb; e.edge_no = k + lat; qb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      chk1("busy_after_start", bus_a.busy, 1'b1);
      chk1("rng_en_after_start", bus_a.rng_en, 1'b1);
      chk1("hfail_cleared", bus_a.health_fail, 1'b0);
      repeat (WARM) @(negedge clk);
      for (int j = 0; j < n; j++) begin
         if (j > 0) chk1("busy_collect", bus_a.busy, 1'b1);
         rng_in = wv[j];
         repeat (SDIV) @(negedge clk);
      end
      if (ok) begin
         if (hold > 0) begin
            repeat (hold) @(negedge clk);
            rand_ready = 1'b1;
         end
         repeat (3) @(negedge clk);
      end
   endtask

   initial begin
      // 1: reset with start held high
      start = 1'b1;
      repeat (2) @(negedge clk);
      chk_idle("reset", 1'b0);
      chk("reset_rand_out", bus_a.rand_out, 64'h0);
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk_idle("post_reset", 1'b0);

      // 2: basic request, forced bits, immediate accept
      wv[0] = 32'h1111_1110; wv[1] = 32'h2222_2222;
      run_req(2, 64'h9111_1110_2222_2223, 64'h1111_1110_2222_2222, 9, 1'b1, 0);

      // 3: consumer stalls 5 cycles
      run_req(2, 64'h9111_1110_2222_2223, 64'h1111_1110_2222_2222, 9, 1'b1, 5);

      // 4: stuck source trips the repetition test on the third discard
      for (int i = 0; i < 4; i++) wv[i] = 32'hDEAD_BEEF;
      run_req(4, 64'h0, 64'h0, 0, 1'b0, 0);
      chk_idle("hfail_abort", 1'b1);
      rng_in = 32'h0BAD_F00D;
      repeat (3) @(negedge clk);
      chk_idle("hfail_sticky", 1'b1);

      // 5: two repeats tolerated, result four cycles later
      wv[0] = 32'h1234_5678; wv[1] = 32'h1234_5678; wv[2] = 32'h1234_5678; wv[3] = 32'h9ABC_DEF0;
      run_req(4, 64'h9234_5678_9ABC_DEF1, 64'h1234_5678_9ABC_DEF0, 13, 1'b1, 0);
      chk1("no_hfail_two_repeats", bus_a.health_fail, 1'b0);

      // 6: reset in COLLECT after one accepted word
      rand_ready = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (WARM) @(negedge clk);
      rng_in = 32'hAAAA_AAAA;
      repeat (SDIV) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_idle("mid_reset", 1'b0);
      chk("mid_reset_rand_out", bus_a.rand_out, 64'h0);
      chk("mid_reset_rand_out_raw", bus_b.rand_out, 64'h0);
      rst = 1'b0;
      wv[0] = 32'h0000_0001; wv[1] = 32'hFFFF_FFFF;
      run_req(2, 64'h8000_0001_FFFF_FFFF, 64'h0000_0001_FFFF_FFFF, 9, 1'b1, 0);

      // 7: first sample equal to the previous request's last word is not a repeat
      wv[0] = 32'hFFFF_FFFF; wv[1] = 32'h0000_0000;
      run_req(2, 64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFF_0000_0000, 9, 1'b1, 0);

      repeat (4) @(negedge clk);
      chk("pending_a", 64'(qa.size()), 64'h0);
      chk("pending_b", 64'(qb.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
